// File: rtl/l2_writeback_queue_if.sv
// ---------------------------------------------------------------------------
// l2_writeback_queue_if
// Purpose : system memory write bus used by the L2 writeback queue to drain
//           dirty lines as multi-beat bursts (valid/ready handshake).
// Signals : valid  - beat valid (driven by the queue)
//           ready  - memory accepts the current beat
//           addr   - 32-bit line base address, constant across a burst
//           data   - BUS_WIDTH bits of the current beat
//           last   - final beat of the burst
// Modports: master - the writeback queue side
//           slave  - the memory side
// ---------------------------------------------------------------------------
interface l2_writeback_queue_if #(
    parameter int BUS_WIDTH = 32
);
    logic                 valid;
    logic                 ready;
    logic [31:0]          addr;
    logic [BUS_WIDTH-1:0] data;
    logic                 last;

    modport master (
        output valid,
        output addr,
        output data,
        output last,
        input  ready
    );

    modport slave (
        input  valid,
        input  addr,
        input  data,
        input  last,
        output ready
    );
endinterface

// File: rtl/l2_writeback_queue.sv
// ---------------------------------------------------------------------------
// l2_writeback_queue
// Purpose : consumer of the L2 read-stage writeback outputs. Evicted/flushed
//           dirty lines (tag, set index, full line data) are held in an
//           in-order FIFO and drained to memory, one line per burst of
//           CACHE_LINE_BITS/BUS_WIDTH beats. A combinational lookup lets the
//           fill path hold off a refill of a line still waiting to be written.
// Ports   : clk               - clock
//           reset             - synchronous, active-low reset
//           wbq_enqueue       - push a dirty line
//           wbq_tag           - tag of the line (TAG_BITS)
//           wbq_set_idx       - set index of the line (SET_BITS)
//           wbq_data          - line data (CACHE_LINE_BITS)
//           wbq_almost_full   - free entries <= AF_MARGIN, upstream must stop
//           wbq_empty         - nothing queued and bus idle
//           wbq_lookup_addr   - {tag,set} probed by the fill path
//           wbq_lookup_hit    - probed line is still queued (combinational)
//           bus               - memory write bus, master side
//           perf_l2_writeback - one-cycle pulse per completed line
// Config  : define L2_WRITEBACK_PERF_EN to enable the perf pulse; when it is
//           undefined perf_l2_writeback is tied low and no flop is built.
// ---------------------------------------------------------------------------
module l2_writeback_queue #(
    parameter int FIFO_DEPTH      = 4,
    parameter int BUS_WIDTH       = 32,
    parameter int AF_MARGIN       = 2,
    parameter int TAG_BITS        = 18,
    parameter int SET_BITS        = 8,
    parameter int CACHE_LINE_BITS = 512
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wbq_enqueue,
    input  logic [TAG_BITS-1:0]          wbq_tag,
    input  logic [SET_BITS-1:0]          wbq_set_idx,
    input  logic [CACHE_LINE_BITS-1:0]   wbq_data,
    output logic                         wbq_almost_full,
    output logic                         wbq_empty,
    input  logic [TAG_BITS+SET_BITS-1:0] wbq_lookup_addr,
    output logic                         wbq_lookup_hit,
    l2_writeback_queue_if.master         bus,
    output logic                         perf_l2_writeback
);

    localparam int BEATS       = CACHE_LINE_BITS / BUS_WIDTH;
    localparam int BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = PTR_W + 1;
    localparam int OFFSET_BITS = 32 - TAG_BITS - SET_BITS;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  AF_CNT    = CNT_W'(AF_MARGIN);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t state;
    state_t state_next;

    logic [TAG_BITS-1:0]        tag_mem  [FIFO_DEPTH];
    logic [SET_BITS-1:0]        set_mem  [FIFO_DEPTH];
    logic [CACHE_LINE_BITS-1:0] data_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]      entry_valid;

    logic [PTR_W-1:0]  head_ptr;
    logic [PTR_W-1:0]  tail_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [BEAT_W-1:0] beat;
    logic              almost_full_q;

    logic full;
    logic enq_ok;
    logic beat_hs;
    logic last_hs;
    logic [CACHE_LINE_BITS-1:0] head_line;

    // An enqueue into a full queue is dropped even if the head is leaving in
    // the same cycle; the upstream is expected to respect almost_full.
    assign full    = (count == DEPTH_CNT);
    assign enq_ok  = wbq_enqueue && !full;
    assign beat_hs = (state == BURST) && bus.ready;
    assign last_hs = beat_hs && (beat == LAST_BEAT);

    // Occupancy after this edge: enqueue and last-beat dequeue cancel out.
    always_comb begin
        count_next = count;
        case ({enq_ok, last_hs})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Burst FSM: IDLE starts a burst whenever something is queued; BURST keeps
    // going straight into the next line after a last beat so there is no bubble.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_next = BURST;
                end
            end
            BURST: begin
                if (last_hs && (count_next == '0)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Control state: pointers, occupancy, valid bits, beat counter and the
    // registered almost_full (computed from the next count so it tracks count).
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            head_ptr      <= '0;
            tail_ptr      <= '0;
            count         <= '0;
            beat          <= '0;
            entry_valid   <= '0;
            almost_full_q <= 1'b0;
        end else begin
            state         <= state_next;
            count         <= count_next;
            almost_full_q <= ((DEPTH_CNT - count_next) <= AF_CNT);
            if (enq_ok) begin
                tail_ptr              <= tail_ptr + PTR_W'(1);
                entry_valid[tail_ptr] <= 1'b1;
            end
            if (last_hs) begin
                head_ptr              <= head_ptr + PTR_W'(1);
                entry_valid[head_ptr] <= 1'b0;
                beat                  <= '0;
            end else if (beat_hs) begin
                beat <= beat + BEAT_W'(1);
            end
        end
    end

    // Line storage needs no reset: entry_valid and count say what is live.
    always_ff @(posedge clk) begin
        if (enq_ok) begin
            tag_mem[tail_ptr]  <= wbq_tag;
            set_mem[tail_ptr]  <= wbq_set_idx;
            data_mem[tail_ptr] <= wbq_data;
        end
    end

    // The head stays addressed until its last beat is accepted, so addr and
    // data are naturally stable while memory stalls.
    assign head_line = data_mem[head_ptr];
    assign bus.valid = (state == BURST);
    assign bus.last  = (state == BURST) && (beat == LAST_BEAT);
    assign bus.addr  = {tag_mem[head_ptr], set_mem[head_ptr], {OFFSET_BITS{1'b0}}};
    assign bus.data  = head_line[int'(beat)*BUS_WIDTH +: BUS_WIDTH];

    // Fill-path probe over every live entry, head included. An enqueue in
    // the same cycle is deliberately not visible here.
    always_comb begin
        wbq_lookup_hit = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (entry_valid[i] && ({tag_mem[i], set_mem[i]} == wbq_lookup_addr)) begin
                wbq_lookup_hit = 1'b1;
            end
        end
    end

    assign wbq_empty       = (count == '0) && (state == IDLE);
    assign wbq_almost_full = almost_full_q;

`ifdef L2_WRITEBACK_PERF_EN
    logic perf_q;

    // One-cycle pulse the cycle after each line's last beat is accepted.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_q <= 1'b0;
        end else begin
            perf_q <= last_hs;
        end
    end

    assign perf_l2_writeback = perf_q;
`else
    assign perf_l2_writeback = 1'b0;
`endif

    // Pushing into a full queue loses a dirty line; flag it in simulation.
    property p_no_enqueue_when_full;
        @(posedge clk) disable iff (!reset) wbq_enqueue |-> !full;
    endproperty

    a_no_enqueue_when_full: assert property (p_no_enqueue_when_full);

endmodule
